// File: rtl/fpga_controller.sv
// fpga_controller: edge-detected buttons drive memory navigation and a step/run FSM that pulses a systolic array.
// Ports: clk, rst (async active-high); start, stepping_enable, step, ReLU_activation, right, left,
// switch_mem_access, mem_read in; addr_FPGA, display_data, mem_sel, compute_step, busy, done out.
module fpga_controller #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  parameter logic [11:0] RESULT_BASE = 12'h400
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stepping_enable,
  input  logic                    step,
  input  logic                    ReLU_activation,
  input  logic                    right,
  input  logic                    left,
  input  logic                    switch_mem_access,
  input  logic signed [WIDTH-1:0] mem_read,
  output logic [11:0]             addr_FPGA,
  output logic signed [WIDTH-1:0] display_data,
  output logic                    mem_sel,
  output logic                    compute_step,
  output logic                    busy,
  output logic                    done
);
  localparam int CELLS = N * N;
  localparam int OW = CELLS > 1 ? $clog2(CELLS) : 1;
  localparam int STEPS = 3 * N - 2;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [OW-1:0] LAST = OW'(CELLS - 1);
  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] btn, btn_q, ev;
  logic [OW-1:0] offset, offset_nx;
  logic [CW-1:0] cnt;
  logic launch, go_right, go_left;
  // ev bits: 4 start, 3 step, 2 right, 1 left, 0 switch
  assign btn = {start, step, right, left, switch_mem_access};
  assign ev = btn & ~btn_q;
  assign busy = state == RUN || state == STEP;
  assign done = state == DONE;
  assign launch = ev[4] & ~busy;
  assign compute_step = state == RUN || (state == STEP && ev[3]);
  assign go_right = ~busy & ev[2] & ~ev[1];
  assign go_left = ~busy & ev[1] & ~ev[2];
  assign addr_FPGA = (mem_sel ? RESULT_BASE : 12'd0) + 12'(offset);
  always_comb begin
    offset_nx = offset;
    if (go_right) offset_nx = offset == LAST ? '0 : offset + 1'b1;
    if (go_left) offset_nx = offset == '0 ? LAST : offset - 1'b1;
  end
  always_comb begin
    state_nx = state;
    if (compute_step && cnt == CW'(STEPS - 1)) state_nx = DONE;
    if (launch) state_nx = stepping_enable ? STEP : RUN;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      btn_q <= '0;
      offset <= '0;
      mem_sel <= 1'b0;
      cnt <= '0;
      display_data <= '0;
    end else begin
      state <= state_nx;
      btn_q <= btn;
      offset <= offset_nx;
      mem_sel <= mem_sel ^ (ev[0] & ~busy);
      cnt <= launch ? '0 : compute_step ? cnt + 1'b1 : cnt;
      display_data <= ReLU_activation && mem_read < 0 ? '0 : mem_read;
    end
  end
endmodule

// File: tb/tb_fpga_controller.sv
// tb_fpga_controller: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_fpga_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stepping_enable = 1'b0, step = 1'b0, ReLU_activation = 1'b0;
  logic right = 1'b0, left = 1'b0, switch_mem_access = 1'b0;
  logic signed [15:0] mem_read = '0;
  logic [11:0] addr_FPGA;
  logic signed [15:0] display_data;
  logic mem_sel, compute_step, busy, done;

  fpga_controller dut (
    .clk(clk), .rst(rst), .start(start), .stepping_enable(stepping_enable), .step(step),
    .ReLU_activation(ReLU_activation), .right(right), .left(left),
    .switch_mem_access(switch_mem_access), .mem_read(mem_read), .addr_FPGA(addr_FPGA),
    .display_data(display_data), .mem_sel(mem_sel), .compute_step(compute_step),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int val; string name;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, pulses = 0, run_len = 0, last_run = 0, snap = 0;

  function automatic integer actual(int k);
    case (k)
      0: return integer'(addr_FPGA);
      1: return integer'(mem_sel);
      2: return integer'(display_data);
      3: return integer'(busy);
      4: return integer'(done);
      5: return integer'(compute_step);
      6: return pulses;
      default: return last_run;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    integer a;
    if (compute_step === 1'b1) begin
      pulses++;
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
      end
    end
  end

  task automatic chk(input int k, input int v, input string name);
    q.push_back('{k, v, name});
    @(negedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    @(posedge clk);
    #1 {start, step, right, left, switch_mem_access} = m;
    @(posedge clk);
    #1 {start, step, right, left, switch_mem_access} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [4:0] B_START = 5'b10000, B_STEP = 5'b01000, B_RIGHT = 5'b00100,
                         B_LEFT = 5'b00010, B_SW = 5'b00001;

  initial begin
    idle(3);
    chk(0, 0, "reset_addr");
    chk(1, 0, "reset_mem_sel");
    chk(2, 0, "reset_display");
    chk(3, 0, "reset_busy");
    chk(4, 0, "reset_done");
    chk(5, 0, "reset_compute_step");
    rst = 1'b0;
    repeat (3) press(B_RIGHT);
    press(B_LEFT);
    chk(0, 2, "nav_addr_2");
    press(B_SW);
    chk(1, 1, "switch_mem_sel_1");
    chk(0, 1026, "switch_addr_402");
    press(B_SW);
    chk(1, 0, "switch_mem_sel_0");
    chk(0, 2, "switch_back_addr_2");
    repeat (2) press(B_LEFT);
    chk(0, 0, "nav_addr_0");
    press(B_LEFT);
    chk(0, 15, "wrap_left_15");
    press(B_RIGHT);
    chk(0, 0, "wrap_right_0");
    press(B_RIGHT | B_LEFT);
    chk(0, 0, "both_at_0");
    press(B_RIGHT);
    press(B_RIGHT | B_LEFT);
    chk(0, 1, "both_at_1");
    mem_read = -16'sd5;
    ReLU_activation = 1'b1;
    idle(1);
    chk(2, 0, "relu_neg_clamped");
    ReLU_activation = 1'b0;
    idle(1);
    chk(2, -5, "no_relu_neg");
    mem_read = 16'sd7;
    ReLU_activation = 1'b1;
    idle(1);
    chk(2, 7, "relu_pos_pass");
    stepping_enable = 1'b1;
    press(B_START);
    chk(3, 1, "step_busy");
    chk(4, 0, "step_not_done");
    chk(6, 0, "step_no_pulse_yet");
    repeat (5) press(B_STEP);
    chk(6, 5, "step_5_pulses");
    chk(3, 1, "step_5_busy");
    chk(4, 0, "step_5_not_done");
    stepping_enable = 1'b0;
    idle(3);
    chk(6, 5, "step_mode_latched");
    repeat (5) press(B_STEP);
    chk(6, 10, "step_10_pulses");
    chk(4, 1, "step_done");
    chk(3, 0, "step_not_busy");
    press(B_STEP);
    chk(6, 10, "step_ignored_in_done");
    press(B_START);
    chk(3, 1, "run_busy");
    chk(4, 0, "run_done_cleared");
    press(B_START | B_RIGHT);
    chk(0, 1, "nav_ignored_busy");
    idle(12);
    chk(4, 1, "run_done");
    chk(6, 20, "run_pulse_total");
    chk(7, 10, "run_consecutive_10");
    press(B_SW);
    chk(0, 1025, "done_switch_addr");
    ReLU_activation = 1'b0;
    idle(1);
    chk(2, 7, "display_before_reset");
    press(B_START);
    idle(3);
    rst = 1'b1;
    snap = pulses;
    chk(0, 0, "midrun_rst_addr");
    chk(1, 0, "midrun_rst_mem_sel");
    chk(2, 0, "midrun_rst_display");
    chk(3, 0, "midrun_rst_busy");
    chk(4, 0, "midrun_rst_done");
    chk(5, 0, "midrun_rst_compute_step");
    idle(2);
    rst = 1'b0;
    idle(4);
    chk(6, snap, "no_pulse_after_rst");
    chk(3, 0, "idle_after_rst");
    idle(2);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpga_controller.md
FPGA_CONTROLLER -- requirements
Module: fpga_controller

Interface
REQ-001 Parameter WIDTH, default 16, data word width of mem_read and display_data.
REQ-002 Parameter N, default 4, systolic array dimension; the navigable region holds N*N words.
REQ-003 Parameter RESULT_BASE, default 12'h400, base address of the result region.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  level; its rising edge launches a computation.
REQ-007 Port stepping_enable  input  1  level; sampled at launch, selects step mode (1) or continuous mode (0).
REQ-008 Port step  input  1  level; each rising edge advances one step in step mode.
REQ-009 Port ReLU_activation  input  1  level; 1 clamps negative display data to zero.
REQ-010 Port right / left  input  1 each  navigation buttons; each rising edge moves the offset by +1 / -1.
REQ-011 Port switch_mem_access  input  1  each rising edge toggles mem_sel.
REQ-012 Port mem_read  input  WIDTH signed  word read from memory at addr_FPGA.
REQ-013 Port addr_FPGA  output  12 unsigned  read address = (mem_sel ? RESULT_BASE : 0) + offset.
REQ-014 Port display_data  output  WIDTH signed  registered, optionally ReLU'd copy of mem_read.
REQ-015 Port mem_sel  output  1  0 = input region, 1 = result region.
REQ-016 Port compute_step  output  1  one-cycle pulse that advances the systolic array one cycle.
REQ-017 Port busy / done  output  1 each  computation in progress / finished.

Function
REQ-018 All button-type inputs (start, step, right, left, switch_mem_access) are edge-detected against a register of the previous cycle's value; an input held high produces exactly one event.
REQ-019 Offset is a counter in 0..N*N-1; a right event at N*N-1 wraps to 0; a left event at 0 wraps to N*N-1.
REQ-020 Simultaneous right and left events in the same cycle leave the offset unchanged.
REQ-021 Navigation and switch events are ignored while busy=1; the offset is preserved across mem_sel toggles.
REQ-022 addr_FPGA is combinational from the offset and mem_sel registers, so it updates in the cycle after the event edge.
REQ-023 display_data is registered each cycle from mem_read (1-cycle latency); if ReLU_activation=1 and mem_read is negative, the registered value is 0.
REQ-024 The FSM has four states: IDLE, RUN, STEP, DONE. IDLE + start event -> STEP if stepping_enable=1, else RUN; the step counter clears on launch.
REQ-025 RUN: compute_step=1 every cycle; the counter increments each pulse; after 3*N-2 pulses (10 for N=4) -> DONE.
REQ-026 STEP: compute_step=1 for exactly one cycle per step event; after 3*N-2 pulses -> DONE; step events in any other state are ignored.
REQ-027 Changes to stepping_enable after launch do not affect the running mode.
REQ-028 busy=1 in RUN and STEP; done=1 in DONE; DONE + start event -> relaunch exactly as from IDLE, with done cleared.
REQ-029 A start event while busy is ignored.

Reset
REQ-030 On rst=1, asynchronously: offset=0, mem_sel=0, addr_FPGA=0, display_data=0, compute_step=0, busy=0, done=0, counter=0, FSM=IDLE, all edge-detect registers=0.
REQ-031 Reset mid-computation aborts immediately to IDLE with no further compute_step pulses.

Verification
REQ-032 Reset, then three 1-cycle right pulses and one left pulse -> addr_FPGA=2.
REQ-033 Continue with one switch_mem_access pulse -> mem_sel=1, addr_FPGA=0x402 (1026); a second pulse -> addr_FPGA=2.
REQ-034 From offset 0: left pulse -> addr_FPGA=15; then right pulse -> 0; right and left pulsed in the same cycle -> unchanged.
REQ-035 stepping_enable=1, start pulse, five step pulses -> exactly 5 compute_step pulses, busy=1, done=0; five more step pulses -> done=1 after the 10th.
REQ-036 stepping_enable=0, start pulse -> 10 consecutive compute_step cycles, then done=1; navigation pulses during busy do not change addr_FPGA.
REQ-037 mem_read=-5 with ReLU_activation=1 -> display_data=0 next cycle; with ReLU_activation=0 -> display_data=-5; rst asserted mid-RUN -> all outputs 0 immediately.
